wptr_sync_level: RTL and testbench

Write-domain companion to the write-pointer handler in the async FIFO. It brings the read-domain Gray read pointer into wclk through a multi-flop synchronizer and feeds the synchronized value to the write-pointer handler. It also converts that pointer to binary, computes the registered write-side fill level, drives a hysteretic almost_full flag, and records write attempts made while full.

---
 rtl/async_fifo_pkg.sv | 30 +++
 rtl/gray2bin_sync.sv | 39 +++
 rtl/wptr_sync_level.sv | 105 ++++++++++
 tb/tb_wptr_sync_level.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared async-FIFO types, constants and Gray/binary helpers for both clock domains.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package async_fifo_pkg;

    typedef enum logic {
        AF_LOW  = 1'b0,
        AF_HIGH = 1'b1
    } af_state_t;

    localparam int             OVF_CNT_W   = 8;
    localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = 8'd255;

    // Helpers work on a fixed wide word; callers zero-extend and truncate.
    localparam int PTR_MAX_W = 16;

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray2bin_sync.sv
// Multi-flop synchronizer for a Gray pointer plus combinational Gray-to-binary decode.
// Latency: STAGES clk edges for q_gray; q_bin follows q_gray combinationally.
// Backpressure: none; samples every cycle.
module gray2bin_sync
    import async_fifo_pkg::*;
#(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic [W-1:0] d_gray,
    output logic [W-1:0] q_gray,
    output logic [W-1:0] q_bin
);

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("gray2bin_sync: STAGES must be 2..4");
    end
    if (W > PTR_MAX_W) begin : g_bad_width
        $error("gray2bin_sync: W exceeds PTR_MAX_W");
    end

    logic [W-1:0] sync_q [STAGES];

    // Plain flop chain: Gray coding guarantees at most one uncertain bit per capture.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= d_gray;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q_gray = sync_q[STAGES-1];
    assign q_bin  = W'(gray2bin(PTR_MAX_W'(q_gray)));

endmodule

// File: rtl/wptr_sync_level.sv
// Write-side read-pointer sync, fill level, hysteretic almost_full and overflow status.
// Latency: g_rptr_sync SYNC_STAGES edges after g_rptr; wlevel/flags 1 edge after their inputs.
// Backpressure: observe-only, never stalls. Optional peak tracking via WLEVEL_PEAK_EN.
module wptr_sync_level
    import async_fifo_pkg::*;
#(
    parameter int PTR_WIDTH   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_SET      = 6,
    parameter int AF_CLR      = 4
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic [PTR_WIDTH:0]   g_rptr,
    input  logic [PTR_WIDTH:0]   b_wptr,
    input  logic                 w_en,
    input  logic                 full,
    input  logic                 ovf_clr,
    output logic [PTR_WIDTH:0]   g_rptr_sync,
    output logic [PTR_WIDTH:0]   wlevel,
    output logic                 almost_full,
    output logic                 ovf,
    output logic [OVF_CNT_W-1:0] ovf_cnt,
    output logic                 ptr_err,
    output logic [PTR_WIDTH:0]   wlevel_peak
);

    localparam int DEPTH = 2 ** PTR_WIDTH;
    typedef logic [PTR_WIDTH:0] ptr_t;
    localparam ptr_t DEPTH_L  = ptr_t'(DEPTH);
    localparam ptr_t AF_SET_L = ptr_t'(AF_SET);
    localparam ptr_t AF_CLR_L = ptr_t'(AF_CLR);

    if (!(AF_CLR < AF_SET && AF_SET <= DEPTH)) begin : g_bad_thresholds
        $error("wptr_sync_level: need AF_CLR < AF_SET <= DEPTH");
    end

    ptr_t      b_rptr_sync;
    ptr_t      lvl_next;
    logic      ovf_evt;
    af_state_t af_state;

    gray2bin_sync #(
        .W      (PTR_WIDTH + 1),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk    (wclk),
        .arst_n (wrst_n),
        .d_gray (g_rptr),
        .q_gray (g_rptr_sync),
        .q_bin  (b_rptr_sync)
    );

    // Modulo subtraction absorbs pointer wrap; the stale read pointer makes this conservative.
    assign lvl_next = b_wptr - b_rptr_sync;
    assign ovf_evt  = w_en & full;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel   <= '0;
            af_state <= AF_LOW;
        end else begin
            wlevel <= lvl_next;
            case (af_state)
                AF_LOW:  if (lvl_next >= AF_SET_L) af_state <= AF_HIGH;
                AF_HIGH: if (lvl_next <= AF_CLR_L) af_state <= AF_LOW;
                default: af_state <= AF_LOW;
            endcase
        end
    end

    assign almost_full = (af_state == AF_HIGH);

    // A fresh overflow in the clearing cycle wins so no event is lost.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
            ptr_err <= 1'b0;
        end else begin
            if (ovf_evt) begin
                ovf <= 1'b1;
                if (ovf_clr)                   ovf_cnt <= OVF_CNT_W'(1);
                else if (ovf_cnt != OVF_CNT_MAX) ovf_cnt <= ovf_cnt + 1'b1;
            end else if (ovf_clr) begin
                ovf     <= 1'b0;
                ovf_cnt <= '0;
            end

            if (lvl_next > DEPTH_L) ptr_err <= 1'b1;
            else if (ovf_clr)       ptr_err <= 1'b0;
        end
    end

`ifdef WLEVEL_PEAK_EN
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n)                    wlevel_peak <= '0;
        else if (ovf_clr)               wlevel_peak <= lvl_next;
        else if (lvl_next > wlevel_peak) wlevel_peak <= lvl_next;
    end
`else
    assign wlevel_peak = '0;
`endif

endmodule

// File: tb/tb_wptr_sync_level.sv
// Scoreboard bench for wptr_sync_level: expected outputs queued at drive time, checked after each edge.
module tb_wptr_sync_level;

    localparam int PW  = 3;
    localparam int SS  = 2;
    localparam int SET = 6;
    localparam int CLR = 4;
    localparam int DEP = 8;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b1;
    logic [3:0] g_rptr = '0, b_wptr = '0;
    logic       w_en = 1'b0, full = 1'b0, ovf_clr = 1'b0;
    logic [3:0] g_rptr_sync, wlevel, wlevel_peak;
    logic       almost_full, ovf, ptr_err;
    logic [7:0] ovf_cnt;

    wptr_sync_level #(.PTR_WIDTH(PW), .SYNC_STAGES(SS), .AF_SET(SET), .AF_CLR(CLR)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .g_rptr(g_rptr), .b_wptr(b_wptr), .w_en(w_en),
        .full(full), .ovf_clr(ovf_clr), .g_rptr_sync(g_rptr_sync), .wlevel(wlevel),
        .almost_full(almost_full), .ovf(ovf), .ovf_cnt(ovf_cnt), .ptr_err(ptr_err),
        .wlevel_peak(wlevel_peak)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [3:0] gs, lvl, peak;
        logic       af, ov, pe;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    logic [3:0] m_sync [SS];
    logic       m_af, m_ovf, m_perr;
    logic [7:0] m_cnt;
    logic [3:0] m_peak;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_sync[i] = '0;
        m_af = 0; m_ovf = 0; m_perr = 0; m_cnt = '0; m_peak = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".gs"},   32'(g_rptr_sync), 0);
        check({tag, ".lvl"},  32'(wlevel), 0);
        check({tag, ".af"},   32'(almost_full), 0);
        check({tag, ".ovf"},  32'(ovf), 0);
        check({tag, ".cnt"},  32'(ovf_cnt), 0);
        check({tag, ".perr"}, 32'(ptr_err), 0);
        check({tag, ".peak"}, 32'(wlevel_peak), 0);
    endtask

    // Drive one cycle, predict the post-edge outputs, then compare after the edge.
    task automatic step(input logic [3:0] g, input logic [3:0] bw,
                        input logic wen, input logic fl, input logic clr);
        exp_t e, a;
        logic [3:0] lvl;
        @(negedge wclk);
        g_rptr = g; b_wptr = bw; w_en = wen; full = fl; ovf_clr = clr;
        lvl = 4'(bw - g2b(m_sync[SS-1]));
        if (!m_af && int'(lvl) >= SET)     m_af = 1;
        else if (m_af && int'(lvl) <= CLR) m_af = 0;
        if (wen && fl) begin
            m_ovf = 1;
            m_cnt = clr ? 8'd1 : ((m_cnt == 8'd255) ? 8'd255 : m_cnt + 8'd1);
        end else if (clr) begin
            m_ovf = 0; m_cnt = 0;
        end
        m_perr = (int'(lvl) > DEP) || (m_perr && !clr);
`ifdef WLEVEL_PEAK_EN
        m_peak = clr ? lvl : ((lvl > m_peak) ? lvl : m_peak);
`else
        m_peak = '0;
`endif
        for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = g;
        e.gs = m_sync[SS-1]; e.lvl = lvl; e.af = m_af; e.ov = m_ovf;
        e.cnt = m_cnt; e.pe = m_perr; e.peak = m_peak;
        exp_q.push_back(e);
        @(posedge wclk);
        #1;
        a = exp_q.pop_front();
        check("g_rptr_sync", 32'(g_rptr_sync), 32'(a.gs));
        check("wlevel",      32'(wlevel),      32'(a.lvl));
        check("almost_full", 32'(almost_full), 32'(a.af));
        check("ovf",         32'(ovf),         32'(a.ov));
        check("ovf_cnt",     32'(ovf_cnt),     32'(a.cnt));
        check("ptr_err",     32'(ptr_err),     32'(a.pe));
        check("wlevel_peak", 32'(wlevel_peak), 32'(a.peak));
    endtask

    initial begin
        model_reset();
        #2 wrst_n = 1'b0;
        #1 check_all_zero("rst_init");
        @(negedge wclk); #2 wrst_n = 1'b1;

        // Sync latency: 0 -> 1 on the read pointer, write pointer at 3.
        repeat (3) step(4'b0000, 4'b0011, 0, 0, 0);
        step(4'b0001, 4'b0011, 0, 0, 0);
        check("lat.edge1_gs", 32'(g_rptr_sync), 0);
        step(4'b0001, 4'b0011, 0, 0, 0);
        check("lat.edge2_gs", 32'(g_rptr_sync), 1);
        check("lat.edge2_lvl", 32'(wlevel), 3);
        step(4'b0001, 4'b0011, 0, 0, 0);
        check("lat.edge3_lvl", 32'(wlevel), 2);

        // Wrap: write pointer 2, read pointer 14 (Gray 1001) -> level 4.
        repeat (4) step(4'b1001, 4'b0010, 0, 0, 0);
        check("wrap.lvl", 32'(wlevel), 4);
        check("wrap.perr", 32'(ptr_err), 0);

        // Hysteresis on levels 5,6,5,4,5 with read pointer settled at 0.
        repeat (4) step(4'b0000, 4'b0101, 0, 0, 0);
        step(4'b0000, 4'b0110, 0, 0, 0); check("hys.6", 32'(almost_full), 1);
        step(4'b0000, 4'b0101, 0, 0, 0); check("hys.5", 32'(almost_full), 1);
        step(4'b0000, 4'b0100, 0, 0, 0); check("hys.4", 32'(almost_full), 0);
        step(4'b0000, 4'b0101, 0, 0, 0); check("hys.5b", 32'(almost_full), 0);

        // Overflow counting, clear-with-event, saturation, clear alone.
        repeat (3) step(4'b0000, 4'b0101, 1, 1, 0);
        check("ovf.cnt3", 32'(ovf_cnt), 3);
        step(4'b0000, 4'b0101, 1, 1, 1);
        check("ovf.clr_evt", 32'(ovf_cnt), 1);
        repeat (300) step(4'b0000, 4'b0101, 1, 1, 0);
        check("ovf.sat", 32'(ovf_cnt), 255);
        step(4'b0000, 4'b0101, 1, 0, 1);
        check("ovf.clr", 32'(ovf), 0);

        // Corruption: level 9 sets ptr_err, which then holds.
        step(4'b0000, 4'b1001, 0, 0, 0);
        check("perr.set", 32'(ptr_err), 1);
        repeat (3) step(4'b0000, 4'b0011, 0, 0, 0);
        check("perr.hold", 32'(ptr_err), 1);
        step(4'b0000, 4'b0011, 0, 0, 1);
        check("perr.clr", 32'(ptr_err), 0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0));
        end

        // Mid-run asynchronous reset with ovf=1 and level=5.
        step(4'b0000, 4'b0101, 0, 0, 1);
        repeat (3) step(4'b0000, 4'b0101, 0, 0, 0);
        step(4'b0000, 4'b0101, 1, 1, 0);
        check("pre_rst.ovf", 32'(ovf), 1);
        check("pre_rst.lvl", 32'(wlevel), 5);
        @(negedge wclk);
        w_en = 0; full = 0;
        #2 wrst_n = 1'b0;
        #1 check_all_zero("rst_async");
        repeat (2) begin
            @(posedge wclk); #1 check_all_zero("rst_held");
        end
        @(negedge wclk); #2 wrst_n = 1'b1;
        model_reset();
        #1 check_all_zero("rst_release");
        repeat (4) step(4'b0000, 4'b0101, 0, 0, 0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
